// File: rtl/dsp_fft_peak_det_pkg.sv
// rtl/dsp_fft_peak_det_pkg.sv - shared defaults and tracker state type for the FFT peak detector
// Purpose: default widths/latencies shared by the detector and its magnitude pipeline,
//          plus the peak tracker state encoding.
// Ports:   none (package).
package dsp_fft_peak_det_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int N_DEF           = 8;
  localparam int MUL_LATENCY_DEF = 2;
  localparam int ADD_LATENCY_DEF = 2;

  typedef enum logic {
    TRK_IDLE = 1'b0,
    TRK_ACC  = 1'b1
  } trk_state_t;

endpackage

// File: rtl/dsp_fft_peak_det_cplx_mag2.sv
// rtl/dsp_fft_peak_det_cplx_mag2.sv - pipelined re^2+im^2 with a sideband tag
// Purpose: squares both halves of a packed {re,im} sample, sums them unsigned, and carries
//          a valid bit plus tag through exactly MUL_LATENCY+ADD_LATENCY register stages.
// Ports:   clk, rst_n          clock, synchronous active-low reset
//          i_data/i_vld/i_tag  packed complex sample, its valid and tag
//          o_mag/o_vld/o_tag   magnitude squared, valid and tag (held while o_vld=0)
module dsp_fft_peak_det_cplx_mag2
  import dsp_fft_peak_det_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int ADD_LATENCY = ADD_LATENCY_DEF,
  parameter int TAG_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*DATA_W-1:0]   i_data,
  input  logic                  i_vld,
  input  logic [TAG_W-1:0]      i_tag,
  output logic [2*DATA_W-1:0]   o_mag,
  output logic                  o_vld,
  output logic [TAG_W-1:0]      o_tag
);

  localparam int PW = 2 * DATA_W;

  logic signed [DATA_W-1:0] w_re;
  logic signed [DATA_W-1:0] w_im;
  logic signed [PW-1:0]     w_re_x;
  logic signed [PW-1:0]     w_im_x;
  logic signed [PW-1:0]     w_sq_re;
  logic signed [PW-1:0]     w_sq_im;

  assign w_re   = i_data[PW-1:DATA_W];
  assign w_im   = i_data[DATA_W-1:0];
  // Sign-extend first so the product is computed at full 2W precision.
  assign w_re_x = {{DATA_W{w_re[DATA_W-1]}}, w_re};
  assign w_im_x = {{DATA_W{w_im[DATA_W-1]}}, w_im};
  assign w_sq_re = w_re_x * w_re_x;
  assign w_sq_im = w_im_x * w_im_x;

  logic [PW-1:0]          r_sq_re [MUL_LATENCY];
  logic [PW-1:0]          r_sq_im [MUL_LATENCY];
  logic [TAG_W-1:0]       r_mtag  [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] r_mvld;

  logic [PW-1:0]          r_sum   [ADD_LATENCY];
  logic [TAG_W-1:0]       r_atag  [ADD_LATENCY];
  logic [ADD_LATENCY-1:0] r_avld;

  logic [PW-1:0]          w_sum_in  [ADD_LATENCY];
  logic [TAG_W-1:0]       w_atag_in [ADD_LATENCY];
  logic [ADD_LATENCY-1:0] w_avld_in;

  always_comb begin
    w_avld_in    = '0;
    // Both squares are <= 2^(2W-2), so the unsigned sum never wraps.
    w_sum_in[0]  = r_sq_re[MUL_LATENCY-1] + r_sq_im[MUL_LATENCY-1];
    w_atag_in[0] = r_mtag[MUL_LATENCY-1];
    w_avld_in[0] = r_mvld[MUL_LATENCY-1];
    for (int i = 1; i < ADD_LATENCY; i++) begin
      w_sum_in[i]  = r_sum[i-1];
      w_atag_in[i] = r_atag[i-1];
      w_avld_in[i] = r_avld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        r_sq_re[i] <= '0;
        r_sq_im[i] <= '0;
        r_mtag[i]  <= '0;
      end
      r_mvld <= '0;
      for (int i = 0; i < ADD_LATENCY; i++) begin
        r_sum[i]  <= '0;
        r_atag[i] <= '0;
      end
      r_avld <= '0;
    end else begin
      r_sq_re[0] <= w_sq_re;
      r_sq_im[0] <= w_sq_im;
      r_mtag[0]  <= i_tag;
      r_mvld[0]  <= i_vld;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_sq_re[i] <= r_sq_re[i-1];
        r_sq_im[i] <= r_sq_im[i-1];
        r_mtag[i]  <= r_mtag[i-1];
        r_mvld[i]  <= r_mvld[i-1];
      end
      for (int i = 0; i < ADD_LATENCY; i++) begin
        r_avld[i] <= w_avld_in[i];
        // The last stage only loads on valid so the output holds across gaps.
        if ((i != ADD_LATENCY - 1) || w_avld_in[i]) begin
          r_sum[i]  <= w_sum_in[i];
          r_atag[i] <= w_atag_in[i];
        end
      end
    end
  end

  assign o_mag = r_sum[ADD_LATENCY-1];
  assign o_tag = r_atag[ADD_LATENCY-1];
  assign o_vld = r_avld[ADD_LATENCY-1];

endmodule

// File: rtl/dsp_fft_peak_det.sv
// rtl/dsp_fft_peak_det.sv - per-bin |X[k]|^2 stream and per-frame peak detector
// Purpose: tags each incoming FFT bin with its index, computes its magnitude squared,
//          and reports the strongest bin (lowest index on ties) once per N-bin frame.
// Ports:   clk, rst_n                    clock, synchronous active-low reset
//          din, din_vld                  packed {re,im} bin in natural order, valid
//          mag_dout, mag_idx, mag_vld    per-bin magnitude stream
//          peak_mag, peak_idx, peak_vld  frame peak, 1-cycle update pulse
module dsp_fft_peak_det
  import dsp_fft_peak_det_pkg::*;
#(
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int N           = N_DEF,
  parameter  int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter  int ADD_LATENCY = ADD_LATENCY_DEF,
  localparam int IDX_W       = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*DATA_W-1:0] din,
  input  logic                din_vld,
  output logic [2*DATA_W-1:0] mag_dout,
  output logic [IDX_W-1:0]    mag_idx,
  output logic                mag_vld,
  output logic [2*DATA_W-1:0] peak_mag,
  output logic [IDX_W-1:0]    peak_idx,
  output logic                peak_vld
);

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N - 1);

  logic [IDX_W-1:0] r_bin_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin_cnt <= '0;
    end else if (din_vld) begin
      r_bin_cnt <= (r_bin_cnt == LAST_BIN) ? '0 : r_bin_cnt + 1'b1;
    end
  end

  logic [2*DATA_W-1:0] w_mag;
  logic [IDX_W-1:0]    w_mag_idx;
  logic                w_mag_vld;

  dsp_fft_peak_det_cplx_mag2 #(
    .DATA_W      (DATA_W),
    .MUL_LATENCY (MUL_LATENCY),
    .ADD_LATENCY (ADD_LATENCY),
    .TAG_W       (IDX_W)
  ) u_mag2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (din),
    .i_vld  (din_vld),
    .i_tag  (r_bin_cnt),
    .o_mag  (w_mag),
    .o_vld  (w_mag_vld),
    .o_tag  (w_mag_idx)
  );

  assign mag_dout = w_mag;
  assign mag_idx  = w_mag_idx;
  assign mag_vld  = w_mag_vld;

  trk_state_t          r_state;
  logic [2*DATA_W-1:0] r_cur_max;
  logic [IDX_W-1:0]    r_cur_idx;
  logic [2*DATA_W-1:0] r_peak_mag;
  logic [IDX_W-1:0]    r_peak_idx;
  logic                r_peak_vld;

  logic                w_take;
  logic [2*DATA_W-1:0] w_nxt_max;
  logic [IDX_W-1:0]    w_nxt_idx;

  // First bin of a frame loads unconditionally; later bins need a strict win,
  // which keeps the lowest index on ties.
  always_comb begin
    w_take    = (r_state == TRK_IDLE) || (w_mag > r_cur_max);
    w_nxt_max = w_take ? w_mag : r_cur_max;
    w_nxt_idx = w_take ? w_mag_idx : r_cur_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= TRK_IDLE;
      r_cur_max  <= '0;
      r_cur_idx  <= '0;
      r_peak_mag <= '0;
      r_peak_idx <= '0;
      r_peak_vld <= 1'b0;
    end else begin
      r_peak_vld <= 1'b0;
      if (w_mag_vld) begin
        if (w_mag_idx == LAST_BIN) begin
          // Final bin: publish and return to IDLE so a back-to-back bin 0 reloads.
          r_peak_mag <= w_nxt_max;
          r_peak_idx <= w_nxt_idx;
          r_peak_vld <= 1'b1;
          r_state    <= TRK_IDLE;
        end else begin
          r_cur_max <= w_nxt_max;
          r_cur_idx <= w_nxt_idx;
          r_state   <= TRK_ACC;
        end
      end
    end
  end

  assign peak_mag = r_peak_mag;
  assign peak_idx = r_peak_idx;
  assign peak_vld = r_peak_vld;

endmodule

// File: tb/tb_dsp_fft_peak_det.sv
// tb/tb_dsp_fft_peak_det.sv - scoreboard bench for the FFT peak detector
module tb_dsp_fft_peak_det;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int ML = 2;
  localparam int AL = 2;
  localparam int L  = ML + AL;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2*W-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic [2*W-1:0] mag_dout;
  logic [IW-1:0] mag_idx;
  logic          mag_vld;
  logic [2*W-1:0] peak_mag;
  logic [IW-1:0] peak_idx;
  logic          peak_vld;

  dsp_fft_peak_det #(
    .DATA_W      (W),
    .N           (N),
    .MUL_LATENCY (ML),
    .ADD_LATENCY (AL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .mag_dout (mag_dout),
    .mag_idx  (mag_idx),
    .mag_vld  (mag_vld),
    .peak_mag (peak_mag),
    .peak_idx (peak_idx),
    .peak_vld (peak_vld)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    longint idx;
    longint cyc;
  } exp_t;

  exp_t   mag_q[$];
  exp_t   peak_q[$];
  longint fr_mag[$];

  int n_pass = 0;
  int n_tot  = 0;

  longint last_mag  = 0;
  longint last_midx = 0;
  longint last_pmag = 0;
  longint last_pidx = 0;

  logic signed [W-1:0] fre [N];
  logic signed [W-1:0] fim [N];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: magnitude from plain integer arithmetic; peak = first index of the maximum.
  task automatic send_bin(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    exp_t   e;
    exp_t   p;
    longint r;
    longint i;
    r = re;
    i = im;
    e.val = r * r + i * i;
    e.idx = fr_mag.size();
    e.cyc = cyc + L;
    mag_q.push_back(e);
    fr_mag.push_back(e.val);
    if (fr_mag.size() == N) begin
      p.val = fr_mag[0];
      p.idx = 0;
      foreach (fr_mag[k]) begin
        if (fr_mag[k] > p.val) begin
          p.val = fr_mag[k];
          p.idx = k;
        end
      end
      p.cyc = cyc + L + 1;
      peak_q.push_back(p);
      fr_mag.delete();
    end
    din     = {re, im};
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // gap < 0 selects a random 0..2 idle cycles after each bin.
  task automatic send_frame(input int gap);
    for (int k = 0; k < N; k++) begin
      send_bin(fre[k], fim[k]);
      if (gap > 0) idle(gap);
      else if (gap < 0) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic clear_frame(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    for (int k = 0; k < N; k++) begin
      fre[k] = re;
      fim[k] = im;
    end
  endtask

  function automatic logic signed [W-1:0] rnd_val(input int mode);
    logic signed [W-1:0] v;
    case (mode)
      0:       v = W'($urandom);
      1:       v = W'($signed($urandom_range(0, 6)) - 3);
      default: begin
        case ($urandom_range(0, 2))
          0:       v = -16'sd32768;
          1:       v = 16'sd32767;
          default: v = '0;
        endcase
      end
    endcase
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    mag_q.delete();
    peak_q.delete();
    fr_mag.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    last_mag  = 0;
    last_midx = 0;
    last_pmag = 0;
    last_pidx = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mag_vld) begin
          chk("mag_expected", longint'(mag_q.size() != 0), 1);
          if (mag_q.size() != 0) begin
            e = mag_q.pop_front();
            chk("mag_dout", longint'(mag_dout), e.val);
            chk("mag_idx", longint'(mag_idx), e.idx);
            chk("mag_latency", cyc, e.cyc);
            last_mag  = e.val;
            last_midx = e.idx;
          end
        end else begin
          chk("mag_hold", longint'(mag_dout), last_mag);
          chk("mag_idx_hold", longint'(mag_idx), last_midx);
        end
        if (peak_vld) begin
          chk("peak_expected", longint'(peak_q.size() != 0), 1);
          if (peak_q.size() != 0) begin
            e = peak_q.pop_front();
            chk("peak_mag", longint'(peak_mag), e.val);
            chk("peak_idx", longint'(peak_idx), e.idx);
            chk("peak_latency", cyc, e.cyc);
            last_pmag = e.val;
            last_pidx = e.idx;
          end
        end else begin
          chk("peak_mag_hold", longint'(peak_mag), last_pmag);
          chk("peak_idx_hold", longint'(peak_idx), last_pidx);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mag_dout", longint'(mag_dout), 0);
    chk("rst_mag_idx", longint'(mag_idx), 0);
    chk("rst_mag_vld", longint'(mag_vld), 0);
    chk("rst_peak_mag", longint'(peak_mag), 0);
    chk("rst_peak_idx", longint'(peak_idx), 0);
    chk("rst_peak_vld", longint'(peak_vld), 0);
    @(posedge clk);
    #1;

    // Impulse at bin 3
    clear_frame(0, 0);
    fre[3] = 16'sd100;
    send_frame(0);
    idle(3);

    // Tie between bins 1 and 5
    clear_frame(1, 1);
    fre[1] = 16'sd30; fim[1] = -16'sd40;
    fre[5] = 16'sd30; fim[5] = -16'sd40;
    send_frame(0);
    idle(3);

    // Full-scale negative corner at bin 6
    clear_frame(0, 0);
    fre[6] = -16'sd32768; fim[6] = -16'sd32768;
    send_frame(0);
    idle(3);

    // Gapped impulse, one valid every third cycle
    clear_frame(0, 0);
    fre[3] = 16'sd100;
    send_frame(2);
    idle(3);

    // Back-to-back: random frame then all-zero frame with no bubble
    for (int k = 0; k < N; k++) begin
      fre[k] = rnd_val(0);
      fim[k] = rnd_val(0);
    end
    send_frame(0);
    clear_frame(0, 0);
    send_frame(0);
    idle(6);

    // Reset after five bins discards the partial frame
    for (int k = 0; k < 5; k++) send_bin(rnd_val(0), rnd_val(0));
    do_reset();
    clear_frame(0, 0);
    fre[2] = 16'sd77; fim[2] = -16'sd5;
    send_frame(0);
    idle(3);

    // Randomized frames with random gaps and value styles
    for (int f = 0; f < 24; f++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < N; k++) begin
        fre[k] = rnd_val(mode);
        fim[k] = rnd_val(mode);
      end
      send_frame(($urandom_range(0, 1) == 0) ? 0 : -1);
    end

    guard = 0;
    while ((mag_q.size() != 0 || peak_q.size() != 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    idle(10);
    chk("drain_mag_q", longint'(mag_q.size()), 0);
    chk("drain_peak_q", longint'(peak_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
